// File: rtl/seq_pkg.sv
// Shared definitions for cpu_rom_sequencer: ROM word layout, FSM encoding and the built-in program.
// Entries 0..2 form the reference program; the remaining words exercise all opcodes.
package seq_pkg;

  localparam int ROM_W        = 20;
  localparam int DATA_W       = 8;
  localparam int OP_W         = 3;
  localparam int PC_W         = 4;
  localparam int MAX_PROG_LEN = 16;

  localparam int USE_ACC_BIT  = 19;
  localparam int OP_LSB       = 16;
  localparam int A_LSB        = 8;
  localparam int B_LSB        = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  // {use_acc, opcode, A, B}
  localparam logic [ROM_W-1:0] SEQ_ROM [MAX_PROG_LEN] = '{
    20'h0_1234, 20'h9_0502, 20'h2_F00F, 20'h3_1122,
    20'h4_3344, 20'h5_5A5A, 20'h6_FF01, 20'h7_0101,
    20'h8_AB00, 20'h1_7F80, 20'h2_0000, 20'hB_0011,
    20'h4_C3C3, 20'hD_0001, 20'h6_8001, 20'h7_FFFF
  };

  function automatic logic word_use_acc(input logic [ROM_W-1:0] w);
    return w[USE_ACC_BIT];
  endfunction

  function automatic logic [OP_W-1:0] word_op(input logic [ROM_W-1:0] w);
    return w[OP_LSB +: OP_W];
  endfunction

  function automatic logic [DATA_W-1:0] word_a(input logic [ROM_W-1:0] w);
    return w[A_LSB +: DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] word_b(input logic [ROM_W-1:0] w);
    return w[B_LSB +: DATA_W];
  endfunction

endpackage

// File: rtl/seq_rom.sv
// Combinational program ROM lookup indexed by pc; no state, zero latency.
module seq_rom
  import seq_pkg::*;
(
  input  logic [PC_W-1:0]  addr,
  output logic [ROM_W-1:0] word
);

  assign word = SEQ_ROM[addr];

endmodule

// File: rtl/cpu_rom_sequencer.sv
// Steps the ROM program onto the CPU side of the mode switch, each instruction held HOLD_CYCLES after its load cycle.
// Optional SEQ_ACC_FWD_EN: instructions with use_acc set take operand A from the captured ALU result.
module cpu_rom_sequencer
  import seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 8,
  parameter int PROG_LEN    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       mode,
  input  logic       loop,
  input  logic [7:0] alu_result,
  output logic [7:0] cpu_a,
  output logic [7:0] cpu_b,
  output logic [2:0] cpu_opcode,
  output logic [3:0] pc,
  output logic       instr_valid,
  output logic       halted
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [PC_W-1:0] LAST_PC  = PC_W'(PROG_LEN - 1);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [ROM_W-1:0]  word;
  logic [DATA_W-1:0] load_a;
  logic              hold_done;

  seq_rom u_rom (
    .addr (pc),
    .word (word)
  );

  // Last enabled HOLD cycle: the outputs have been stable long enough to sample the ALU.
  assign hold_done = mode && ena && (state == ST_HOLD) && (cnt == '0);

`ifdef SEQ_ACC_FWD_EN
  logic [DATA_W-1:0] acc;

  assign load_a = word_use_acc(word) ? acc : word_a(word);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (hold_done) begin
      acc <= alu_result;
    end
  end
`else
  logic unused_inputs;

  assign load_a        = word_a(word);
  assign unused_inputs = ^{alu_result, word_use_acc(word)};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pc          <= '0;
      cpu_a       <= '0;
      cpu_b       <= '0;
      cpu_opcode  <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (!mode) begin
      // Manual mode: operands keep their last values so the switch sees no glitch.
      state       <= ST_IDLE;
      pc          <= '0;
      halted      <= 1'b0;
      instr_valid <= 1'b0;
    end else if (!ena) begin
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          cpu_a       <= load_a;
          cpu_b       <= word_b(word);
          cpu_opcode  <= word_op(word);
          instr_valid <= 1'b1;
          cnt         <= CNT_LOAD;
          state       <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_done) begin
            if (pc < LAST_PC) begin
              pc    <= pc + 4'd1;
              state <= ST_LOAD;
            end else if (loop) begin
              pc    <= '0;
              state <= ST_LOAD;
            end else begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
